// File: rtl/product_stream_reader_if.sv
// Valid/ready stream carrying one product from the bank, tagged with its row/column indices.
interface product_stream_if #(
  parameter int ACC_WIDTH = 16,
  parameter int IW        = 2,
  parameter int JW        = 2
);
  logic                 valid;
  logic                 ready;
  logic [ACC_WIDTH-1:0] data;
  logic [IW-1:0]        row;
  logic [JW-1:0]        col;
  logic                 last;

  modport master (output valid, data, row, col, last, input ready);
  modport slave  (input valid, data, row, col, last, output ready);
endinterface

// File: rtl/product_stream_reader.sv
// Scans the N_IN x N_SEL product bank on a start pulse and streams each product with its indices,
// flagging any bank write that lands while the scan is running.
module product_stream_reader #(
  parameter int N_IN      = 4,
  parameter int N_SEL     = 4,
  parameter int ACC_WIDTH = 16,
  parameter int IW        = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int JW        = (N_SEL > 1) ? $clog2(N_SEL) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [N_IN*N_SEL*ACC_WIDTH-1:0] prod_in,
  input  logic [N_SEL-1:0]               bank_we,
  output logic                           busy,
  output logic                           done,
  output logic                           hazard,
  product_stream_if.master               out
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t               state, state_next;
  logic [IW-1:0]        i, i_next;
  logic [JW-1:0]        j, j_next;
  logic                 load;
  logic                 at_last;
  logic [ACC_WIDTH-1:0] data_q;
  logic                 hazard_q;
  logic [ACC_WIDTH-1:0] prod_arr [N_IN][N_SEL];

  // Element (i,j) sits at flat offset (i*N_SEL + j)*ACC_WIDTH.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_row
    for (genvar gj = 0; gj < N_SEL; gj++) begin : g_col
      assign prod_arr[gi][gj] = prod_in[(gi*N_SEL+gj)*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  assign at_last = (i == IW'(N_IN-1)) && (j == JW'(N_SEL-1));

  always_comb begin
    state_next = state;
    i_next     = i;
    j_next     = j;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          i_next     = '0;
          j_next     = '0;
          load       = 1'b1;
          state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        if (out.ready) begin
          if (at_last) begin
            state_next = S_DONE;
          end else begin
            load = 1'b1;
            if (j == JW'(N_SEL-1)) begin
              j_next = '0;
              i_next = i + 1'b1;
            end else begin
              j_next = j + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      i        <= '0;
      j        <= '0;
      data_q   <= '0;
      hazard_q <= 1'b0;
    end else begin
      state <= state_next;
      i     <= i_next;
      j     <= j_next;
      if (load) begin
        data_q <= prod_arr[i_next][j_next];
      end
      // An accepted start clears the flag; busy is still low then, so a same-cycle write is ignored.
      if (state == S_IDLE && start) begin
        hazard_q <= 1'b0;
      end else if (busy && (|bank_we)) begin
        hazard_q <= 1'b1;
      end
    end
  end

  assign busy      = (state == S_STREAM);
  assign done      = (state == S_DONE);
  assign hazard    = hazard_q;
  assign out.valid = (state == S_STREAM);
  assign out.data  = data_q;
  assign out.row   = i;
  assign out.col   = j;
  assign out.last  = (state == S_STREAM) && at_last;

endmodule

// File: tb/tb_product_stream_reader.sv
// Directed bench for product_stream_reader on a 4x4 bank holding prod[i][j] = 16*i + j.
module tb_product_stream_reader;

  localparam int N_IN      = 4;
  localparam int N_SEL     = 4;
  localparam int ACC_WIDTH = 16;
  localparam int IW        = 2;
  localparam int JW        = 2;

  logic                            clk = 1'b0;
  logic                            rst_n;
  logic                            start;
  logic [N_IN*N_SEL*ACC_WIDTH-1:0] prod_in;
  logic [N_SEL-1:0]                bank_we;
  logic                            busy;
  logic                            done;
  logic                            hazard;

  int n_assert = 0;
  int n_fail   = 0;

  product_stream_if #(.ACC_WIDTH(ACC_WIDTH), .IW(IW), .JW(JW)) out ();

  product_stream_reader #(
    .N_IN(N_IN), .N_SEL(N_SEL), .ACC_WIDTH(ACC_WIDTH), .IW(IW), .JW(JW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .prod_in(prod_in),
    .bank_we(bank_we),
    .busy(busy),
    .done(done),
    .hazard(hazard),
    .out(out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_data(input int k);
    return 16'(16 * (k / 4) + (k % 4));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_n = 1'b0;
    start = 1'b0;
    bank_we = '0;
    out.ready = 1'b0;
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_SEL; j++)
        prod_in[(i*N_SEL+j)*ACC_WIDTH +: ACC_WIDTH] = 16'(16 * i + j);
    tick();
    tick();
    n_assert++;
    if ({out.valid, out.data, out.row, out.col, out.last, busy, done, hazard} !== 24'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got valid=%b data=%h row=%0d col=%0d last=%b busy=%b done=%b hazard=%b, expected all 0",
               out.valid, out.data, out.row, out.col, out.last, busy, done, hazard);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_assert++;
    if ({out.valid, busy, done} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_release_idle: got valid=%b busy=%b done=%b, expected 000", out.valid, busy, done);
    end
  endtask

  task automatic test_basic();
    $display("[TB] test_basic");
    out.ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_assert++;
      if ({out.valid, out.data, out.row, out.col, out.last, busy, done} !==
          {1'b1, exp_data(k), 2'(k / 4), 2'(k % 4), (k == 15), 1'b1, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL basic_elem_%0d: got valid=%b data=%0d row=%0d col=%0d last=%b busy=%b done=%b, expected 1 %0d %0d %0d %b 1 0",
                 k, out.valid, out.data, out.row, out.col, out.last, busy, done, exp_data(k), k / 4, k % 4, k == 15);
      end
      tick();
    end
    n_assert++;
    if ({done, out.valid, busy} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL basic_done_pulse: got done=%b valid=%b busy=%b, expected 100", done, out.valid, busy);
    end
    tick();
    n_assert++;
    if ({done, out.valid, busy} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL basic_after_done: got done=%b valid=%b busy=%b, expected 000", done, out.valid, busy);
    end
  endtask

  task automatic test_backpressure();
    int  k;
    int  cyc;
    logic rdy;
    $display("[TB] test_backpressure");
    out.ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 16 && cyc < 400) begin
      n_assert++;
      if ({out.valid, out.data, out.row, out.col, out.last, done} !==
          {1'b1, exp_data(k), 2'(k / 4), 2'(k % 4), (k == 15), 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL bp_elem_%0d_cyc_%0d: got valid=%b data=%0d row=%0d col=%0d last=%b done=%b, expected 1 %0d %0d %0d %b 0",
                 k, cyc, out.valid, out.data, out.row, out.col, out.last, done, exp_data(k), k / 4, k % 4, k == 15);
      end
      rdy = ($urandom_range(0, 99) < 30);
      out.ready = rdy;
      tick();
      cyc++;
      if (rdy) k++;
    end
    n_assert++;
    if (k != 16) begin
      n_fail++;
      $display("[TB] FAIL bp_timeout: got %0d transfers, expected 16", k);
    end
    n_assert++;
    if ({done, out.valid} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL bp_done: got done=%b valid=%b, expected 10", done, out.valid);
    end
    out.ready = 1'b1;
    tick();
  endtask

  task automatic test_hazard();
    $display("[TB] test_hazard");
    out.ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_assert++;
      if ({out.valid, out.data, out.row, out.col} !== {1'b1, exp_data(k), 2'(k / 4), 2'(k % 4)}) begin
        n_fail++;
        $display("[TB] FAIL hz_elem_%0d: got valid=%b data=%0d row=%0d col=%0d, expected 1 %0d %0d %0d",
                 k, out.valid, out.data, out.row, out.col, exp_data(k), k / 4, k % 4);
      end
      if (k == 5) begin
        n_assert++;
        if (hazard !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL hz_before_write: got hazard=%b, expected 0", hazard);
        end
        bank_we = 4'b0010;
      end
      if (k == 6) begin
        bank_we = 4'b0000;
        n_assert++;
        if (hazard !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL hz_after_write: got hazard=%b, expected 1", hazard);
        end
      end
      tick();
    end
    n_assert++;
    if ({done, hazard} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL hz_held_in_done: got done=%b hazard=%b, expected 11", done, hazard);
    end
    tick();
    n_assert++;
    if ({busy, hazard} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL hz_held_in_idle: got busy=%b hazard=%b, expected 01", busy, hazard);
    end
    start = 1'b1;
    bank_we = 4'b0001;
    tick();
    start = 1'b0;
    bank_we = 4'b0000;
    n_assert++;
    if ({out.valid, hazard} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL hz_cleared_by_start: got valid=%b hazard=%b, expected 10", out.valid, hazard);
    end
    for (int k = 0; k < 16; k++) tick();
    n_assert++;
    if ({done, hazard} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL hz_clean_scan_done: got done=%b hazard=%b, expected 10", done, hazard);
    end
    tick();
  endtask

  task automatic test_start_busy();
    int done_count;
    $display("[TB] test_start_busy");
    out.ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    done_count = 0;
    for (int k = 0; k < 16; k++) begin
      n_assert++;
      if ({out.valid, out.data, out.row, out.col, out.last} !==
          {1'b1, exp_data(k), 2'(k / 4), 2'(k % 4), (k == 15)}) begin
        n_fail++;
        $display("[TB] FAIL sb_elem_%0d: got valid=%b data=%0d row=%0d col=%0d last=%b, expected 1 %0d %0d %0d %b",
                 k, out.valid, out.data, out.row, out.col, out.last, exp_data(k), k / 4, k % 4, k == 15);
      end
      if (done) done_count++;
      start = (k == 3 || k == 10);
      tick();
    end
    start = 1'b0;
    if (done) done_count++;
    n_assert++;
    if (done_count != 1) begin
      n_fail++;
      $display("[TB] FAIL sb_done_count: got %0d done pulses, expected 1", done_count);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_assert++;
    if ({out.valid, busy, done} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL sb_idle_after_done: got valid=%b busy=%b done=%b, expected 000", out.valid, busy, done);
    end
    tick();
    n_assert++;
    if ({out.valid, busy} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL sb_start_in_done_ignored: got valid=%b busy=%b, expected 00", out.valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    int done_count;
    $display("[TB] test_reset_mid");
    out.ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    n_assert++;
    if ({out.valid, out.data, out.row, out.col} !== {1'b1, exp_data(7), 2'd1, 2'd3}) begin
      n_fail++;
      $display("[TB] FAIL rm_elem_7: got valid=%b data=%0d row=%0d col=%0d, expected 1 19 1 3",
               out.valid, out.data, out.row, out.col);
    end
    rst_n = 1'b0;
    #1;
    n_assert++;
    if ({out.valid, out.data, out.row, out.col, out.last, busy, done, hazard} !== 24'h0) begin
      n_fail++;
      $display("[TB] FAIL rm_async_clear: got valid=%b data=%0d row=%0d col=%0d last=%b busy=%b done=%b hazard=%b, expected all 0",
               out.valid, out.data, out.row, out.col, out.last, busy, done, hazard);
    end
    done_count = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done) done_count++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    if (done) done_count++;
    n_assert++;
    if (done_count != 0) begin
      n_fail++;
      $display("[TB] FAIL rm_no_done: got %0d done pulses, expected 0", done_count);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_assert++;
    if ({out.valid, out.data, out.row, out.col} !== {1'b1, 16'd0, 2'd0, 2'd0}) begin
      n_fail++;
      $display("[TB] FAIL rm_restart_first: got valid=%b data=%0d row=%0d col=%0d, expected 1 0 0 0",
               out.valid, out.data, out.row, out.col);
    end
    for (int k = 0; k < 16; k++) tick();
    n_assert++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rm_restart_done: got done=%b, expected 1", done);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    out.ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 16; k++) begin
        n_assert++;
        if ({out.valid, out.data, out.row, out.col, out.last} !==
            {1'b1, exp_data(k), 2'(k / 4), 2'(k % 4), (k == 15)}) begin
          n_fail++;
          $display("[TB] FAIL b2b_scan%0d_elem_%0d: got valid=%b data=%0d row=%0d col=%0d last=%b, expected 1 %0d %0d %0d %b",
                   s, k, out.valid, out.data, out.row, out.col, out.last, exp_data(k), k / 4, k % 4, k == 15);
        end
        tick();
      end
      n_assert++;
      if ({done, out.valid} !== 2'b10) begin
        n_fail++;
        $display("[TB] FAIL b2b_scan%0d_done: got done=%b valid=%b, expected 10", s, done, out.valid);
      end
      tick();
      n_assert++;
      if ({done, out.valid, busy} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL b2b_scan%0d_idle: got done=%b valid=%b busy=%b, expected 000", s, done, out.valid, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_hazard();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
